// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Instruction decode stage. It takes one fetched instruction at a time,
// strobes the register file read ports in the accept cycle, and captures the
// returned operands one cycle later. It then presents a decoded bundle
// (IR, PC, X, Y) downstream with a valid/ready handshake.
//
// A per-register busy scoreboard blocks read-after-write hazards against
// results that have left this stage but have not yet been written back.
//
// Optional feature (compile-time macro): DECODE_WB_BYPASS_EN
//   When this macro is defined, a writeback that targets a busy source
//   releases the interlock in the same cycle. The writeback value is then
//   used in place of the register file data. When the macro is undefined,
//   the stage stalls until the busy bit has cleared and always uses rdN_data.
//
// Opcode map (IR[31:26]):
//   6'h00        NOP
//   6'h01-6'h0F  R_TYPE  X=R[Rs]       Y=R[Rt]        writes Rd
//   6'h10-6'h1F  I_TYPE  X=R[Rs]       Y=sext(Imm)    writes Rd
//   6'h20-6'h27  branch  X=R[Rd]       Y=sext(Imm)
//   6'h28-6'h2A  SD/SH/SW X=R[Rd]      Y=R[Rs]
//   6'h30-6'h31  J_TYPE  X=zext(Tgt)   Y=0
//   6'h3F        HALT
//   others       undefined, treated like NOP (X=Y=0)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        upstream handshake; in_ir, in_pc instruction/PC
//   out_valid/out_ready      downstream handshake
//   out_ir/out_pc/out_x/out_y decoded bundle
//   rd1_*/rd2_*              register file read ports (data valid next cycle)
//   wb_en/wb_addr/wb_data    writeback notification
//   flush                    discard the in-flight instruction
//   halted                   a HALT bundle has left the stage
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_ir,
  input  logic [WIDTH-3:0]        in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_ir,
  output logic [WIDTH-3:0]        out_pc,
  output logic [WIDTH-1:0]        out_x,
  output logic [WIDTH-1:0]        out_y,
  output logic                    rd1_en,
  output logic                    rd2_en,
  output logic [REG_ADDR_LEN-1:0] rd1_addr,
  output logic [REG_ADDR_LEN-1:0] rd2_addr,
  input  logic [WIDTH-1:0]        rd1_data,
  input  logic [WIDTH-1:0]        rd2_data,
  input  logic                    wb_en,
  input  logic [REG_ADDR_LEN-1:0] wb_addr,
  input  logic [WIDTH-1:0]        wb_data,
  input  logic                    flush,
  output logic                    halted
);

  localparam int NREG = 2 ** REG_ADDR_LEN;

  localparam logic [5:0] OP_R_FIRST  = 6'h01;
  localparam logic [5:0] OP_R_LAST   = 6'h0F;
  localparam logic [5:0] OP_I_FIRST  = 6'h10;
  localparam logic [5:0] OP_I_LAST   = 6'h1F;
  localparam logic [5:0] OP_BR_FIRST = 6'h20;
  localparam logic [5:0] OP_BR_LAST  = 6'h27;
  localparam logic [5:0] OP_ST_FIRST = 6'h28;
  localparam logic [5:0] OP_ST_LAST  = 6'h2A;
  localparam logic [5:0] OP_J_FIRST  = 6'h30;
  localparam logic [5:0] OP_J_LAST   = 6'h31;
  localparam logic [5:0] OP_HALT     = 6'h3F;

  localparam logic [WIDTH-1:0] NOP_IR = '0;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_R, CLS_I, CLS_BR, CLS_ST, CLS_J, CLS_HALT
  } op_cls_t;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD} state_t;

  function automatic op_cls_t classify(input logic [5:0] op);
    op_cls_t c;
    c = CLS_NONE;
    if (op >= OP_R_FIRST && op <= OP_R_LAST)        c = CLS_R;
    else if (op >= OP_I_FIRST && op <= OP_I_LAST)   c = CLS_I;
    else if (op >= OP_BR_FIRST && op <= OP_BR_LAST) c = CLS_BR;
    else if (op >= OP_ST_FIRST && op <= OP_ST_LAST) c = CLS_ST;
    else if (op >= OP_J_FIRST && op <= OP_J_LAST)   c = CLS_J;
    else if (op == OP_HALT)                         c = CLS_HALT;
    return c;
  endfunction

  // Instruction register fields are always 5 bits wide. Resize them to the
  // configured register address width.
  function automatic logic [REG_ADDR_LEN-1:0] to_addr(input logic [4:0] f);
    return REG_ADDR_LEN'(f);
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t            state_reg;
  logic              out_valid_reg;
  logic [WIDTH-1:0]  out_ir_reg;
  logic [WIDTH-3:0]  out_pc_reg;
  logic [WIDTH-1:0]  out_x_reg;
  logic [WIDTH-1:0]  out_y_reg;
  logic              halted_reg;
  logic [WIDTH-1:0]  ir_q_reg;
  logic [WIDTH-3:0]  pc_q_reg;
  logic [NREG-1:0]   busy_vec;

  // -------------------------------------------------------------------------
  // Incoming instruction decode
  // -------------------------------------------------------------------------
  op_cls_t                 in_cls;
  logic                    src1_used;
  logic                    src2_used;
  logic [REG_ADDR_LEN-1:0] src1_addr;
  logic [REG_ADDR_LEN-1:0] src2_addr;

  assign in_cls = classify(in_ir[31:26]);

  // Port 1 always supplies X and port 2 always supplies Y. This keeps the
  // operand mux in READ independent of which field fed each port.
  always_comb begin
    src1_used = 1'b0;
    src2_used = 1'b0;
    src1_addr = to_addr(in_ir[20:16]);
    src2_addr = to_addr(in_ir[15:11]);
    case (in_cls)
      CLS_R: begin
        src1_used = 1'b1;
        src2_used = 1'b1;
      end
      CLS_I: src1_used = 1'b1;
      CLS_BR: begin
        src1_used = 1'b1;
        src1_addr = to_addr(in_ir[25:21]);
      end
      CLS_ST: begin
        src1_used = 1'b1;
        src2_used = 1'b1;
        src1_addr = to_addr(in_ir[25:21]);
        src2_addr = to_addr(in_ir[20:16]);
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Held bundle properties
  // -------------------------------------------------------------------------
  op_cls_t                 out_cls;
  logic                    out_writes;
  logic [REG_ADDR_LEN-1:0] hold_dest;
  logic                    hold_wr;
  logic                    hold_halt;

  assign out_cls    = classify(out_ir_reg[31:26]);
  assign hold_dest  = to_addr(out_ir_reg[25:21]);
  assign out_writes = (out_cls == CLS_R || out_cls == CLS_I) && (hold_dest != '0);
  assign hold_wr    = (state_reg == S_HOLD) && out_writes;
  assign hold_halt  = (state_reg == S_HOLD) && (out_cls == CLS_HALT);

  // -------------------------------------------------------------------------
  // RAW interlock
  // A bundle that is held here and writes a register is not in the scoreboard
  // yet. Its destination is checked directly, so that an instruction accepted
  // in the same cycle as its fire cannot read a stale value.
  // -------------------------------------------------------------------------
  logic src1_busy;
  logic src2_busy;
  logic src1_sb;
  logic src2_sb;
  logic raw_stall;

`ifdef DECODE_WB_BYPASS_EN
  assign src1_sb = busy_vec[src1_addr] && !(wb_en && wb_addr == src1_addr);
  assign src2_sb = busy_vec[src2_addr] && !(wb_en && wb_addr == src2_addr);
`else
  assign src1_sb = busy_vec[src1_addr];
  assign src2_sb = busy_vec[src2_addr];
`endif

  assign src1_busy = src1_used && (src1_addr != '0) &&
                     (src1_sb || (hold_wr && src1_addr == hold_dest));
  assign src2_busy = src2_used && (src2_addr != '0) &&
                     (src2_sb || (hold_wr && src2_addr == hold_dest));
  assign raw_stall = src1_busy || src2_busy;

  // -------------------------------------------------------------------------
  // Handshakes
  // -------------------------------------------------------------------------
  logic accept;
  logic fire;

  always_comb begin
    in_ready = 1'b0;
    if (!rst && !halted_reg && !flush && !raw_stall && !hold_halt) begin
      in_ready = (state_reg == S_IDLE) || ((state_reg == S_HOLD) && out_ready);
    end
  end

  assign accept = in_valid && in_ready;
  assign fire   = out_valid_reg && out_ready && !flush;

  assign rd1_en   = accept && src1_used;
  assign rd2_en   = accept && src2_used;
  assign rd1_addr = rd1_en ? src1_addr : '0;
  assign rd2_addr = rd2_en ? src2_addr : '0;

  // -------------------------------------------------------------------------
  // Operand selection in READ
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] opnd1;
  logic [WIDTH-1:0] opnd2;

`ifdef DECODE_WB_BYPASS_EN
  logic [REG_ADDR_LEN-1:0] src1_q_reg;
  logic [REG_ADDR_LEN-1:0] src2_q_reg;
  logic                    byp1_valid_reg;
  logic                    byp2_valid_reg;
  logic [WIDTH-1:0]        byp1_data_reg;
  logic [WIDTH-1:0]        byp2_data_reg;

  // The register file may return pre-write data for a write landing in the
  // accept cycle. So a writeback seen at accept is latched here. A writeback
  // seen during READ itself is newer and takes priority over the latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src1_q_reg     <= '0;
      src2_q_reg     <= '0;
      byp1_valid_reg <= 1'b0;
      byp2_valid_reg <= 1'b0;
      byp1_data_reg  <= '0;
      byp2_data_reg  <= '0;
    end else if (accept) begin
      src1_q_reg     <= src1_used ? src1_addr : '0;
      src2_q_reg     <= src2_used ? src2_addr : '0;
      byp1_valid_reg <= src1_used && (src1_addr != '0) && wb_en && (wb_addr == src1_addr);
      byp2_valid_reg <= src2_used && (src2_addr != '0) && wb_en && (wb_addr == src2_addr);
      byp1_data_reg  <= wb_data;
      byp2_data_reg  <= wb_data;
    end
  end

  always_comb begin
    opnd1 = rd1_data;
    opnd2 = rd2_data;
    if (byp1_valid_reg) opnd1 = byp1_data_reg;
    if (byp2_valid_reg) opnd2 = byp2_data_reg;
    if (wb_en && (src1_q_reg != '0) && (wb_addr == src1_q_reg)) opnd1 = wb_data;
    if (wb_en && (src2_q_reg != '0) && (wb_addr == src2_q_reg)) opnd2 = wb_data;
  end
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;

  assign opnd1 = rd1_data;
  assign opnd2 = rd2_data;
`endif

  op_cls_t          q_cls;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] tgt_zext;
  logic [WIDTH-1:0] x_next;
  logic [WIDTH-1:0] y_next;

  assign q_cls    = classify(ir_q_reg[31:26]);
  assign imm_sext = {{(WIDTH-16){ir_q_reg[15]}}, ir_q_reg[15:0]};
  assign tgt_zext = {{(WIDTH-26){1'b0}}, ir_q_reg[25:0]};

  always_comb begin
    x_next = '0;
    y_next = '0;
    case (q_cls)
      CLS_R, CLS_ST: begin
        x_next = opnd1;
        y_next = opnd2;
      end
      CLS_I, CLS_BR: begin
        x_next = opnd1;
        y_next = imm_sext;
      end
      CLS_J: x_next = tgt_zext;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Busy scoreboard: one flop per register. A fire sets the bit and a
  // writeback clears it. If both hit the same register in one cycle, the set
  // wins. Register 0 is hard-wired free.
  // -------------------------------------------------------------------------
  logic busy_set;
  assign busy_set = fire && out_writes;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_vec[gi] = 1'b0;
      end else begin : g_bit
        logic busy_reg;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            busy_reg <= 1'b0;
          end else if (busy_set && hold_dest == REG_ADDR_LEN'(gi)) begin
            busy_reg <= 1'b1;
          end else if (wb_en && wb_addr == REG_ADDR_LEN'(gi)) begin
            busy_reg <= 1'b0;
          end
        end
        assign busy_vec[gi] = busy_reg;
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Control FSM and output bundle.
  // Accept is only possible in IDLE, or in HOLD while firing. So the
  // instruction capture is independent of the state case.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      out_valid_reg <= 1'b0;
      out_ir_reg    <= NOP_IR;
      out_pc_reg    <= '0;
      out_x_reg     <= '0;
      out_y_reg     <= '0;
      halted_reg    <= 1'b0;
      ir_q_reg      <= NOP_IR;
      pc_q_reg      <= '0;
    end else if (flush) begin
      state_reg     <= S_IDLE;
      out_valid_reg <= 1'b0;
      out_ir_reg    <= NOP_IR;
      out_pc_reg    <= '0;
      out_x_reg     <= '0;
      out_y_reg     <= '0;
    end else begin
      if (accept) begin
        ir_q_reg <= in_ir;
        pc_q_reg <= in_pc;
      end
      case (state_reg)
        S_IDLE: begin
          if (accept) state_reg <= S_READ;
        end
        S_READ: begin
          out_ir_reg    <= ir_q_reg;
          out_pc_reg    <= pc_q_reg;
          out_x_reg     <= x_next;
          out_y_reg     <= y_next;
          out_valid_reg <= 1'b1;
          state_reg     <= S_HOLD;
        end
        S_HOLD: begin
          if (fire) begin
            out_valid_reg <= 1'b0;
            if (out_cls == CLS_HALT) halted_reg <= 1'b1;
            state_reg <= accept ? S_READ : S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_ir    = out_ir_reg;
  assign out_pc    = out_pc_reg;
  assign out_x     = out_x_reg;
  assign out_y     = out_y_reg;
  assign halted    = halted_reg;

endmodule
